// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, per-key debounce FSM, press pulses,
// and a slow buttonClock with butt_n realigned to its falling edge.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 1250000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_n,
  output logic [3:0] butt_n,
  output logic       buttonClock,
  output logic [3:0] press_pulse,
  output logic [3:0] held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [TW-1:0] tick_cnt;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    key_state_t    state;
    logic [CW-1:0] cnt;
    logic          key_held;
    logic          key_pulse;

    // NOTE: held and press_pulse are set on the transition edge itself, so they stay glitch-free registers.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state     <= RELEASED;
        cnt       <= '0;
        key_held  <= 1'b0;
        key_pulse <= 1'b0;
      end else begin
        key_pulse <= 1'b0;
        case (state)
          RELEASED: begin
            if (!sync2[gi]) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (sync2[gi]) begin
              state <= RELEASED;
            end else if (cnt == CNT_LAST) begin
              state     <= PRESSED;
              key_held  <= 1'b1;
              key_pulse <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          PRESSED: begin
            if (sync2[gi]) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end
          end
          RELEASE_WAIT: begin
            // A bounce back to pressed returns silently: no new press pulse.
            if (!sync2[gi]) begin
              state <= PRESSED;
            end else if (cnt == CNT_LAST) begin
              state    <= RELEASED;
              key_held <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end

    assign held[gi]        = key_held;
    assign press_pulse[gi] = key_pulse;
  end

  // butt_n only changes on the buttonClock falling edge, giving a full half-period of setup before each rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt    <= '0;
      buttonClock <= 1'b0;
      butt_n      <= 4'b1111;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt    <= '0;
      buttonClock <= ~buttonClock;
      if (buttonClock) begin
        butt_n <= ~held;
      end
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

endmodule
